// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and default parameters for fifo_push_arbiter
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int STAT_W         = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting one past last_grant
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - credit-based round-robin push arbiter; FIFO_ARB_STATS_EN adds grant counters
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push,
  output logic [DATA_W-1:0]             fifo_data_in,
  input  logic                          fifo_pop_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
  input  logic                          stat_clr,
  output logic [STAT_W-1:0]             stat_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   credits
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] FULL_CRED = CRED_W'(FIFO_DEPTH);

  arb_state_t         state;
  arb_state_t         state_d;
  logic [CRED_W-1:0]  credits_d;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  sel_word;
  logic               any_valid;
  logic               has_credit;
  logic               handshake;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx)
  );

  assign any_valid  = |req_valid;
  assign has_credit = (credits != '0);
  // Gated by reset_n so nothing is accepted while the arbiter is held in reset.
  assign req_ready  = (reset_n && has_credit) ? pick_oh : '0;
  assign handshake  = |(req_valid & req_ready);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) sel_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  // A grant and a returned credit in the same cycle cancel; returns at a full pool are dropped.
  always_comb begin
    credits_d = credits;
    if (handshake && !fifo_pop_done) begin
      credits_d = credits - CRED_W'(1);
    end else if (!handshake && fifo_pop_done && credits != FULL_CRED) begin
      credits_d = credits + CRED_W'(1);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (any_valid) state_d = has_credit ? ISSUE : STALL;
      end
      ISSUE: begin
        if (!any_valid)            state_d = IDLE;
        else if (credits_d == '0)  state_d = STALL;
      end
      STALL: begin
        if (!any_valid)            state_d = IDLE;
        else if (fifo_pop_done)    state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      credits      <= FULL_CRED;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      fifo_push    <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
    end else begin
      state     <= state_d;
      credits   <= credits_d;
      fifo_push <= handshake;
      if (handshake) begin
        last_grant   <= pick_idx;
        grant_id     <= pick_idx;
        fifo_data_in <= sel_word;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (handshake && grant_cnt[pick_idx] != '1) begin
      grant_cnt[pick_idx] <= grant_cnt[pick_idx] + STAT_W'(1);
    end
  end

  assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 4, width of one FIFO word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the downstream FIFO (credit pool size).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester word-available flag.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_W, requester i's word in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot accept strobe; word i is taken when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port fifo_push, output, 1, registered push strobe to the FIFO.
REQ-010 SHALL have port fifo_data_in, output, DATA_W, registered word that goes with fifo_push.
REQ-011 SHALL have port fifo_pop_done, input, 1, one-cycle pulse that returns one credit when the FIFO consumer pops.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ), index of the requester behind the current fifo_push.
REQ-013 SHALL have port credits, output, clog2(FIFO_DEPTH)+1, current free-entry count.

Function
REQ-014 SHALL keep a credit counter that starts at FIFO_DEPTH, drops by 1 per fifo_push, and rises by 1 per fifo_pop_done.
REQ-015 SHALL leave credits unchanged in a cycle with both a push and a pop_done.
REQ-016 SHALL saturate credits at FIFO_DEPTH and ignore a pop_done that arrives at FIFO_DEPTH.
REQ-017 SHALL never let credits go below 0, so no push is ever issued at 0 credits.
REQ-018 SHALL use FSM states IDLE, ISSUE and STALL.
REQ-019 SHALL transition IDLE->ISSUE when any req_valid is set and credits > 0.
REQ-020 SHALL transition IDLE->STALL when any req_valid is set and credits == 0.
REQ-021 SHALL transition ISSUE->STALL when this cycle's grant brings credits to 0 and no pop_done arrives in the same cycle.
REQ-022 SHALL transition ISSUE->IDLE when no req_valid is set.
REQ-023 SHALL transition STALL->ISSUE on pop_done while any req_valid is set, and STALL->IDLE when no req_valid is set.
REQ-024 SHALL, in any cycle with credits > 0 and any req_valid set, combinationally assert req_ready for exactly one requester, chosen round-robin.
REQ-025 SHALL start the round-robin search at (last_grant+1) mod NUM_REQ, with last_grant reset to NUM_REQ-1.
REQ-026 SHALL, one cycle after a handshake, register fifo_push=1, fifo_data_in=the accepted word and grant_id=its index; fifo_push is 0 otherwise.
REQ-027 SHALL update last_grant only on a completed handshake.
REQ-028 SHALL sustain one grant per cycle while credits stay above 0.
REQ-029 SHALL apply a pop_done in the same cycle as a grant at credits==1, so a back-to-back grant is allowed next cycle.
REQ-030 SHALL keep req_ready at 0 whenever credits == 0, including in STALL.

Reset
REQ-031 SHALL, while reset_n is low, force state=IDLE, credits=FIFO_DEPTH, last_grant=NUM_REQ-1, fifo_push=0, fifo_data_in=0, grant_id=0 and req_ready=0.
REQ-032 SHALL make reset asynchronous on assertion, and SHALL discard an in-flight registered push when reset hits mid-operation.
REQ-033 SHALL start grants on the first rising edge after deassertion; the FIFO is reset alongside the arbiter.

Configuration
REQ-034 SHALL, with FIFO_ARB_STATS_EN defined, add input stat_sel (clog2(NUM_REQ) bits), output stat_cnt (8 bits, the selected requester's grant count, saturating at 255) and input stat_clr (synchronous clear of all counters).
REQ-035 SHALL, without FIFO_ARB_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-036 SHALL place the FSM state typedef (IDLE/ISSUE/STALL) and the default-parameter constants in the shared package fifo_arb_pkg.
REQ-037 SHALL implement the round-robin selection as sub-module rr_pick: combinational, inputs request vector and last_grant, outputs one-hot grant and index.

Verification
REQ-038 SHALL cover reset: with reset_n=0, credits=4, req_ready=0, fifo_push=0; after release with req_valid=4'b0001, req_ready=4'b0001 and fifo_push=1 one cycle later.
REQ-039 SHALL cover round-robin: with req_valid=4'b1111 held and no pops, grants go 0,1,2,3, then credits=0, state=STALL and req_ready=0.
REQ-040 SHALL cover credit return: in STALL with req_valid=4'b0100, one fifo_pop_done pulse gives a grant to requester 2 next cycle and credits returns to 0.
REQ-041 SHALL cover simultaneous push/pop: at credits=1, a grant plus pop_done in the same cycle leaves credits=1 and allows a grant the next cycle.
REQ-042 SHALL cover reset mid-operation: reset_n is pulsed low while credits=2 and fifo_push=1; fifo_push drops immediately and credits=4.
REQ-043 SHALL cover the stats option: with FIFO_ARB_STATS_EN, after 6 grants to requester 1, stat_sel=1 gives stat_cnt=6, and stat_clr gives 0.
